// File: rtl/pdm_audio_pkg.sv
// rtl/pdm_audio_pkg.sv - shared widths, frame length and transmitter state encoding
package pdm_audio_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int FRAME_LEN = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/pdm_sd_mod.sv
// rtl/pdm_sd_mod.sv - first-order accumulator modulator; the carry out is the PDM bit
module pdm_sd_mod #(
    parameter int W = pdm_audio_pkg::SAMPLE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_step,
    input  logic [W-1:0] i_sample,
    output logic         o_carry
);

    logic [W-1:0] r_acc;
    logic [W:0]   w_sum;

    // The sum wraps modulo 2^W; only the carry leaves this block.
    assign w_sum   = {1'b0, r_acc} + {1'b0, i_sample};
    assign o_carry = w_sum[W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_step) begin
            r_acc <= w_sum[W-1:0];
        end
    end

endmodule

// File: rtl/pdm_audio_tx.sv
// rtl/pdm_audio_tx.sv - buffered PDM audio transmitter with frame-aligned sample reload
module pdm_audio_tx #(
    parameter int SAMPLE_W  = pdm_audio_pkg::SAMPLE_W,
    parameter int FRAME_LEN = pdm_audio_pkg::FRAME_LEN
) (
    input  logic                clk_2MHz,
    input  logic                btnRST,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] audDATA,
    input  logic                aud_valid,
    output logic                aud_ready,
    output logic                audPWM,
    output logic                audSD,
    output logic                underrun
);
    import pdm_audio_pkg::*;

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_LEN - 1);

    state_t              r_state;
    logic [SAMPLE_W-1:0] r_buf;
    logic                r_buf_full;
    logic [SAMPLE_W-1:0] r_cur;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ready;
    logic                r_pwm;
    logic                r_sd;
    logic                r_underrun;

    logic w_boundary;
    logic w_accept;
    logic w_take;
    logic w_buf_full_next;
    logic w_clear;
    logic w_step;
    logic w_carry;

    always_comb begin
        w_boundary      = (r_state == RUN) && (r_cnt == '0);
        w_accept        = aud_valid && r_ready;
        // A stop request at the boundary suppresses the reload.
        w_take          = r_buf_full && en &&
                          ((r_state == PRIME) || w_boundary);
        w_buf_full_next = w_accept || (r_buf_full && !w_take);
        w_clear         = (r_state != RUN) || (w_boundary && !en);
        w_step          = (r_state == RUN);
    end

    pdm_sd_mod #(
        .W (SAMPLE_W)
    ) u_sd_mod (
        .clk      (clk_2MHz),
        .rst      (btnRST),
        .i_clear  (w_clear),
        .i_step   (w_step),
        .i_sample (r_cur),
        .o_carry  (w_carry)
    );

    always_ff @(posedge clk_2MHz or posedge btnRST) begin
        if (btnRST) begin
            r_state    <= IDLE;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_cur      <= '0;
            r_cnt      <= CNT_MAX;
            r_ready    <= 1'b0;
            r_pwm      <= 1'b0;
            r_sd       <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_buf_full <= w_buf_full_next;
            r_ready    <= !w_buf_full_next;
            r_underrun <= 1'b0;
            if (w_accept) begin
                r_buf <= audDATA;
            end
            if (w_take) begin
                r_cur <= r_buf;
            end

            case (r_state)
                IDLE: begin
                    r_cnt <= CNT_MAX;
                    r_pwm <= 1'b0;
                    r_sd  <= 1'b0;
                    if (en) begin
                        r_state <= PRIME;
                    end
                end
                PRIME: begin
                    r_cnt <= CNT_MAX;
                    r_pwm <= 1'b0;
                    if (!en) begin
                        r_state <= IDLE;
                        r_sd    <= 1'b0;
                    end else if (r_buf_full) begin
                        r_state <= RUN;
                        r_sd    <= 1'b1;
                    end
                end
                RUN: begin
                    r_pwm <= w_carry;
                    if (w_boundary) begin
                        r_cnt <= CNT_MAX;
                        if (!en) begin
                            r_state <= IDLE;
                            r_sd    <= 1'b0;
                            r_pwm   <= 1'b0;
                        end else if (!r_buf_full) begin
                            // Sample is repeated; a same-cycle accept waits for the next boundary.
                            r_underrun <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_sd    <= 1'b0;
                    r_pwm   <= 1'b0;
                end
            endcase
        end
    end

    assign aud_ready = r_ready;
    assign audPWM    = r_pwm;
    assign audSD     = r_sd;
    assign underrun  = r_underrun;

endmodule

// File: doc/pdm_audio_tx.md
PDM_AUDIO_TX -- requirements
Module: pdm_audio_tx

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, meaning audio sample width.
REQ-002 SHALL have parameter FRAME_LEN, default 16, meaning clocks per sample frame.
REQ-003 SHALL have port clk_2MHz, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port btnRST, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port en, input, 1 bit: audio output enable.
REQ-006 SHALL have port audDATA, input, SAMPLE_W bits: unsigned offset-binary sample.
REQ-007 SHALL have port aud_valid, input, 1 bit: audDATA is valid.
REQ-008 SHALL have port aud_ready, output, 1 bit: registered; block accepts audDATA.
REQ-009 SHALL have port audPWM, output, 1 bit: registered PDM bit stream.
REQ-010 SHALL have port audSD, output, 1 bit: amplifier enable, high in RUN only.
REQ-011 SHALL have port underrun, output, 1 bit: one-clock pulse.

Function
REQ-012 SHALL hold one-entry buffer buf/buf_full; accept when aud_valid && aud_ready; next-cycle aud_ready = !buf_full_next.
REQ-013 SHALL use an FSM with states IDLE, PRIME and RUN.
REQ-014 IDLE: audSD=0, audPWM=0, frame counter held at FRAME_LEN-1, accumulator 0; buffer still accepts.
REQ-015 IDLE->PRIME when en=1; PRIME->RUN on first clock with buf_full=1, moving buf to cur, clearing buf_full, clearing accumulator.
REQ-016 PRIME->IDLE when en=0 before buffer fills.
REQ-017 RUN: frame counter decrements each clock, wrapping 0 -> FRAME_LEN-1.
REQ-018 RUN, per clock: acc17 = {0,acc[15:0]} + {0,cur}; audPWM <= acc17[16]; acc[15:0] <= acc17[15:0].
REQ-019 Latency: first audPWM bit of a newly loaded cur SHALL appear the clock after the load.
REQ-020 Frame boundary (counter==0 in RUN) with buf_full=1: cur <= buf, buf_full <= 0.
REQ-021 Frame boundary with buf_full=0: cur unchanged (sample repeated); underrun=1 for that clock.
REQ-022 Simultaneous boundary and accept into empty buffer: underrun SHALL still pulse; new sample stays in buf for the next boundary.
REQ-023 en=0 in RUN: finish current frame; at boundary go to IDLE, audSD<=0, audPWM<=0, no load, no underrun.
REQ-024 Accumulator SHALL wrap modulo 2^SAMPLE_W; carry out is the only output bit.

Reset
REQ-025 btnRST=1 SHALL immediately force: state IDLE, buf_full=0, cur=16'h0000, acc=0, counter=FRAME_LEN-1, aud_ready=0, audPWM=0, audSD=0, underrun=0.
REQ-026 aud_ready SHALL rise on the first clock after btnRST release; reset mid-frame discards buf and cur.

Structure
REQ-027 Shared package pdm_audio_pkg SHALL hold SAMPLE_W, FRAME_LEN, and the state encoding (IDLE, PRIME, RUN).
REQ-028 SHALL instantiate one sub-module pdm_sd_mod: the accumulator/carry modulator with clear and step inputs.

Verification
REQ-029 Reset mid-RUN -> audPWM=0, audSD=0, aud_ready=0 at once; aud_ready=1 one clock after release; state IDLE.
REQ-030 en=1, continuous 16'h8000 -> audPWM alternates 0,1 from the first RUN bit; exactly 8 ones per 16-clock frame.
REQ-031 Stream 16'h0000 -> 0 ones per frame. Stream 16'hFFFF -> 15 ones in the first frame after clear, 16 in each following frame.
REQ-032 Hold aud_valid with buffer full -> aud_ready=0; sample accepted on the clock after the next boundary; no sample lost or duplicated.
REQ-033 Supply one sample 16'hC000 then stop -> underrun pulse at the next boundary; 12 ones per frame continue (sample repeated).
REQ-034 Drop en at counter=9 in RUN -> audSD stays 1 for 9 more clocks, then 0; audPWM=0; state IDLE; no underrun.
